// File: rtl/clk_tick_sched.sv
// Multi-channel programmable clock-enable scheduler: NCH independent one-cycle tick strobes,
// each with a runtime divide ratio updated through a valid/ready port at period boundaries.
module clk_tick_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_chan,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_en,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);

  logic [NCH-1:0][DW-1:0] act_div_q, act_div_d;
  logic [NCH-1:0][DW-1:0] shd_div_q, shd_div_d;
  logic [NCH-1:0][DW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         act_en_q, act_en_d;
  logic [NCH-1:0]         shd_en_q, shd_en_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic [NCH-1:0]         sel;

  // An out-of-range channel selects nothing, so it is always ready and its request is dropped.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) begin
      sel[i] = (cfg_chan == CW'(i));
    end
  end

  assign cfg_ready = ~|(sel & pend_q);

  always_comb begin
    act_div_d = act_div_q;
    shd_div_d = shd_div_q;
    cnt_d     = cnt_q;
    act_en_d  = act_en_q;
    shd_en_d  = shd_en_q;
    pend_d    = pend_q;
    tick_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (act_en_q[i]) begin
        if (cnt_q[i] == act_div_q[i]) begin
          tick_d[i] = 1'b1;
          cnt_d[i]  = '0;
          // Wrap edge is the only point a running channel may change period.
          if (pend_q[i]) begin
            act_div_d[i] = shd_div_q[i];
            act_en_d[i]  = shd_en_q[i];
            pend_d[i]    = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end else begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          act_div_d[i] = shd_div_q[i];
          act_en_d[i]  = shd_en_q[i];
          pend_d[i]    = 1'b0;
        end
      end
      // Handshake only possible while not pending, so it never collides with an apply.
      if (cfg_valid && cfg_ready && sel[i]) begin
        shd_div_d[i] = cfg_div;
        shd_en_d[i]  = cfg_en;
        pend_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_div_q <= '0;
      shd_div_q <= '0;
      cnt_q     <= '0;
      act_en_q  <= '0;
      shd_en_q  <= '0;
      pend_q    <= '0;
      tick_q    <= '0;
    end else begin
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      cnt_q     <= cnt_d;
      act_en_q  <= act_en_d;
      shd_en_q  <= shd_en_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clk_tick_sched.sv
// Bench for clk_tick_sched (NCH=3): directed scenarios plus random traffic, checked against a
// model that schedules each channel's next wrap as an absolute cycle number.
module tb_clk_tick_sched;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_chan = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  clk_tick_sched #(.NCH(NCH), .DW(DW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: edge count, and per channel the absolute edge of the next wrap.
  longint         t = 0;
  bit             m_run  [NCH];
  bit             m_sen  [NCH];
  bit             m_pend [NCH];
  int             m_div  [NCH];
  int             m_sdiv [NCH];
  longint         m_next [NCH];
  logic [NCH-1:0] exp_tick = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0d: got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic model_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic logic [NCH-1:0] model_pend();
    logic [NCH-1:0] p;
    for (int i = 0; i < NCH; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic model_edge(input logic v, input int ch, input int dv, input logic e,
                            input logic r);
    logic hs;
    hs = v && model_ready(ch);
    t++;
    exp_tick = '0;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 0; m_sen[i] = 0; m_pend[i] = 0; m_div[i] = 0; m_sdiv[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_run[i]) begin
          if (t == m_next[i]) begin
            exp_tick[i] = 1'b1;
            if (m_pend[i]) begin
              m_run[i] = m_sen[i]; m_div[i] = m_sdiv[i]; m_pend[i] = 0;
            end
            m_next[i] = t + m_div[i] + 1;
          end
        end else if (m_pend[i]) begin
          m_run[i] = m_sen[i]; m_div[i] = m_sdiv[i]; m_pend[i] = 0;
          m_next[i] = t + m_div[i] + 1;
        end
      end
      if (hs && ch < NCH) begin
        m_sdiv[ch] = dv; m_sen[ch] = e; m_pend[ch] = 1;
      end
    end
  endtask

  task automatic cycle(input logic v, input int ch, input int dv, input logic e, input logic r);
    @(negedge clk);
    cfg_valid = v;
    cfg_chan  = ch[CW-1:0];
    cfg_div   = dv[DW-1:0];
    cfg_en    = e;
    rst       = r;
    #1;
    check_eq("cfg_ready", 32'(cfg_ready), 32'(model_ready(ch)));
    @(posedge clk);
    model_edge(v, ch, dv, e, r);
    #1;
    check_eq("tick", 32'(tick), 32'(exp_tick));
    check_eq("pending", 32'(pending), 32'(model_pend()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Hold the request until the model says it is taken; bounded.
  task automatic send_cfg(input int ch, input int dv, input logic e);
    logic rdy;
    logic done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      rdy = model_ready(ch);
      cycle(1'b1, ch, dv, e, 1'b0);
      done = rdy;
    end
    check_eq("cfg_accept", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_sen[i] = 0; m_pend[i] = 0; m_div[i] = 0; m_sdiv[i] = 0; m_next[i] = 0;
    end

    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    idle(3);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);

    // ch0 div=1: pending one cycle, first tick three edges after acceptance, then every 2nd.
    send_cfg(0, 1, 1'b1);
    idle(9);

    // ch1 div=3, retuned to 5 when its count is 1.
    send_cfg(1, 3, 1'b1);
    for (int k = 0; k < 20 && m_next[1] != t + 3; k++) idle(1);
    check_eq("ch1_phase", 32'(m_next[1] == t + 3), 32'd1);
    send_cfg(1, 5, 1'b1);
    idle(20);

    // ch2 div=0 continuous, then disabled: one last tick.
    send_cfg(2, 0, 1'b1);
    idle(5);
    send_cfg(2, 0, 1'b0);
    idle(5);
    check_eq("ch2_silent", 32'(tick[2]), 32'd0);

    // Mid-run single-cycle reset clears everything.
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    check_eq("midrst_tick", 32'(tick), 32'd0);
    check_eq("midrst_pending", 32'(pending), 32'd0);
    idle(2);

    // Out-of-range channel is accepted and ignored.
    cycle(1'b1, 3, 7, 1'b1, 1'b0);
    cycle(1'b1, 3, 2, 1'b1, 1'b0);
    idle(4);
    check_eq("oor_pending", 32'(pending), 32'd0);

    // Align ch0 and ch1 at div=2 via ch1 retune landing on ch0's first wrap.
    send_cfg(0, 2, 1'b1);
    send_cfg(1, 1, 1'b1);
    send_cfg(1, 2, 1'b1);
    idle(12);
    check_eq("coincident", 32'(m_next[0] == m_next[1]), 32'd1);

    // Reset on the same edge as a ch0 wrap with an update pending.
    send_cfg(0, 4, 1'b1);
    for (int k = 0; k < 20 && m_next[0] != t + 1; k++) idle(1);
    check_eq("pre_rst_pend", 32'(pending[0]), 32'd1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    check_eq("wrap_rst_tick", 32'(tick), 32'd0);
    check_eq("wrap_rst_pending", 32'(pending), 32'd0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check_eq("ch0_idle", 32'(tick[0]), 32'd0);
    end

    // Random traffic, including out-of-range channels and occasional reset.
    for (int k = 0; k < 700; k++) begin
      int dv;
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), dv,
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
